// File: rtl/spram_arb_pkg.sv
// Shared types and constants for the two-port SPRAM arbiter.
// Imported by the arbiter top and its round-robin sub-module.
package spram_arb_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/spram_arbiter_if.sv
// Requester and RAM-side signals for the SPRAM arbiter.
// The arbiter uses the slave modport; requesters and the RAM model use master.
interface spram_arbiter_if #(
  parameter int ADDR_W = spram_arb_pkg::ADDR_W,
  parameter int DATA_W = spram_arb_pkg::DATA_W
);

  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              ack0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              ack1;
  logic [DATA_W-1:0] rdata1;

  logic              ram_wea;
  logic [ADDR_W-1:0] ram_addra;
  logic [DATA_W-1:0] ram_dina;
  logic [DATA_W-1:0] ram_douta;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  ram_douta,
    output ack0, rdata0, ack1, rdata1,
    output ram_wea, ram_addra, ram_dina
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output ram_douta,
    input  ack0, rdata0, ack1, rdata1,
    input  ram_wea, ram_addra, ram_dina
  );

endinterface

// File: rtl/spram_arbiter_rr.sv
// Two-way round-robin pick: a masked-out requester never wins, and a tie
// goes to the port that did not win last time.
module rr_arbiter2
  import spram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_id
);

  logic [1:0] eligible;

  assign eligible = req & ~mask;

  always_comb begin
    grant_valid = |eligible;
    grant_id    = PORT_FETCH;
    case (eligible)
      2'b01:   grant_id = PORT_FETCH;
      2'b10:   grant_id = PORT_DATA;
      2'b11:   grant_id = ~last_grant;
      default: grant_id = PORT_FETCH;
    endcase
  end

endmodule

// File: rtl/spram_arbiter.sv
// Serialises fetch (port 0) and load/store (port 1) accesses onto one
// single-port synchronous RAM; each access takes an ACCESS and a RESP cycle.
module spram_arbiter
  import spram_arb_pkg::*;
#(
  parameter int ADDR_W = spram_arb_pkg::ADDR_W,
  parameter int DATA_W = spram_arb_pkg::DATA_W
) (
  input  logic            clk,
  input  logic            rst,
  spram_arbiter_if.slave  bus
);

  state_t            state;
  state_t            state_next;

  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              winner;
  logic              last_grant;

  logic [1:0]        req_vec;
  logic [1:0]        mask;
  logic              grant_valid;
  logic              grant_id;
  logic              load;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign req_vec = {bus.req1, bus.req0};

  // While responding, the port being acked must not win the next slot.
  assign mask = (state == RESP) ? ((winner == PORT_DATA) ? 2'b10 : 2'b01)
                                : 2'b00;

  rr_arbiter2 u_rr (
    .req         (req_vec),
    .mask        (mask),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign sel_we    = (grant_id == PORT_DATA) ? bus.we1    : bus.we0;
  assign sel_addr  = (grant_id == PORT_DATA) ? bus.addr1  : bus.addr0;
  assign sel_wdata = (grant_id == PORT_DATA) ? bus.wdata1 : bus.wdata0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    load          = 1'b0;
    bus.ram_wea   = 1'b0;
    bus.ack0      = 1'b0;
    bus.ack1      = 1'b0;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          load       = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        bus.ram_wea = cmd_we;
        state_next  = RESP;
      end
      RESP: begin
        bus.ack0 = (winner == PORT_FETCH);
        bus.ack1 = (winner == PORT_DATA);
        if (grant_valid) begin
          load       = 1'b1;
          state_next = ACCESS;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Command is captured at grant time so requesters changing inputs later
  // cannot disturb an access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_we     <= 1'b0;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
      winner     <= PORT_FETCH;
      last_grant <= PORT_DATA;
    end else if (load) begin
      cmd_we     <= sel_we;
      cmd_addr   <= sel_addr;
      cmd_wdata  <= sel_wdata;
      winner     <= grant_id;
      last_grant <= grant_id;
    end
  end

  assign bus.ram_addra = cmd_addr;
  assign bus.ram_dina  = cmd_wdata;
  assign bus.rdata0    = bus.ram_douta;
  assign bus.rdata1    = bus.ram_douta;

endmodule

// File: tb/tb_spram_arbiter.sv
// Self-checking bench for spram_arbiter with a behavioural SPRAM and a
// serialised-memory reference model.
module tb_spram_arbiter;
  import spram_arb_pkg::*;

  logic clk = 1'b0;
  logic rst;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] ram     [64];
  logic [31:0] ref_mem [64];

  always #5 clk = ~clk;

  spram_arbiter_if bus ();

  spram_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Synchronous single-port RAM, one cycle read latency.
  always @(posedge clk) begin
    if (bus.ram_wea) ram[bus.ram_addra] <= bus.ram_dina;
    bus.ram_douta <= ram[bus.ram_addra];
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    n_checks++; if (bus.ack0 !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_ack0 got=%b exp=0", bus.ack0); end
    n_checks++; if (bus.ack1 !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_ack1 got=%b exp=0", bus.ack1); end
    n_checks++; if (bus.ram_wea !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_wea got=%b exp=0", bus.ram_wea); end
    n_checks++; if (bus.ram_addra !== 6'd0) begin n_errors++; $display("[TB] FAIL reset_addr got=%0d exp=0", bus.ram_addra); end
    n_checks++; if (bus.ram_dina !== 32'd0) begin n_errors++; $display("[TB] FAIL reset_din got=%h exp=0", bus.ram_dina); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    do_reset();
    ram[5] = 32'hDEADBEEF; ref_mem[5] = 32'hDEADBEEF;
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 6'd5;
    tick();
    n_checks++; if (bus.ram_addra !== 6'd5) begin n_errors++; $display("[TB] FAIL rd_access_addr got=%0d exp=5", bus.ram_addra); end
    n_checks++; if (bus.ram_wea !== 1'b0) begin n_errors++; $display("[TB] FAIL rd_access_wea got=%b exp=0", bus.ram_wea); end
    n_checks++; if (bus.ack0 !== 1'b0) begin n_errors++; $display("[TB] FAIL rd_early_ack0 got=%b exp=0", bus.ack0); end
    tick();
    n_checks++; if (bus.ack0 !== 1'b1) begin n_errors++; $display("[TB] FAIL rd_ack0 got=%b exp=1", bus.ack0); end
    n_checks++; if (bus.rdata0 !== 32'hDEADBEEF) begin n_errors++; $display("[TB] FAIL rd_data0 got=%h exp=deadbeef", bus.rdata0); end
    n_checks++; if (bus.ack1 !== 1'b0) begin n_errors++; $display("[TB] FAIL rd_ack1 got=%b exp=0", bus.ack1); end
    bus.req0 = 1'b0;
    tick();
    n_checks++; if (bus.ack0 !== 1'b0) begin n_errors++; $display("[TB] FAIL rd_ack0_pulse got=%b exp=0", bus.ack0); end
  endtask

  task automatic test_write_read();
    int wea_cycles;
    bit acked;
    do_reset();
    wea_cycles = 0;
    acked = 1'b0;
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 6'd10; bus.wdata1 = 32'h12345678;
    for (int c = 0; c < 8 && !acked; c++) begin
      tick();
      if (bus.ram_wea === 1'b1) wea_cycles++;
      if (bus.ack1 === 1'b1) begin acked = 1'b1; bus.req1 = 1'b0; end
    end
    n_checks++; if (acked !== 1'b1) begin n_errors++; $display("[TB] FAIL wr_ack1 got=%b exp=1 (timeout)", acked); end
    n_checks++; if (wea_cycles != 1) begin n_errors++; $display("[TB] FAIL wr_wea_cycles got=%0d exp=1", wea_cycles); end
    ref_mem[10] = 32'h12345678;
    tick();
    n_checks++; if (bus.ram_wea !== 1'b0) begin n_errors++; $display("[TB] FAIL wr_wea_after got=%b exp=0", bus.ram_wea); end
    acked = 1'b0;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 6'd10; bus.wdata1 = 32'h0;
    for (int c = 0; c < 8 && !acked; c++) begin
      tick();
      if (bus.ack1 === 1'b1) begin
        acked = 1'b1;
        n_checks++; if (bus.rdata1 !== 32'h12345678) begin n_errors++; $display("[TB] FAIL wr_readback got=%h exp=12345678", bus.rdata1); end
        bus.req1 = 1'b0;
      end
    end
    n_checks++; if (acked !== 1'b1) begin n_errors++; $display("[TB] FAIL wr_read_ack1 got=%b exp=1 (timeout)", acked); end
    tick();
  endtask

  task automatic test_both_same_cycle();
    logic [5:0] a0, a1;
    do_reset();
    a0 = 6'($urandom_range(0, 31));
    a1 = 6'($urandom_range(32, 63));
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = a0;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = a1;
    tick();
    n_checks++; if (bus.ram_addra !== a0) begin n_errors++; $display("[TB] FAIL tie_first_addr got=%0d exp=%0d", bus.ram_addra, a0); end
    tick();
    n_checks++; if (bus.ack0 !== 1'b1) begin n_errors++; $display("[TB] FAIL tie_ack0 got=%b exp=1", bus.ack0); end
    n_checks++; if (bus.ack1 !== 1'b0) begin n_errors++; $display("[TB] FAIL tie_ack1_early got=%b exp=0", bus.ack1); end
    n_checks++; if (bus.rdata0 !== ref_mem[a0]) begin n_errors++; $display("[TB] FAIL tie_rdata0 got=%h exp=%h", bus.rdata0, ref_mem[a0]); end
    bus.req0 = 1'b0;
    tick();
    n_checks++; if (bus.ram_addra !== a1) begin n_errors++; $display("[TB] FAIL tie_no_gap_addr got=%0d exp=%0d", bus.ram_addra, a1); end
    tick();
    n_checks++; if (bus.ack1 !== 1'b1) begin n_errors++; $display("[TB] FAIL tie_ack1 got=%b exp=1", bus.ack1); end
    n_checks++; if (bus.rdata1 !== ref_mem[a1]) begin n_errors++; $display("[TB] FAIL tie_rdata1 got=%h exp=%h", bus.rdata1, ref_mem[a1]); end
    bus.req1 = 1'b0;
    tick();
  endtask

  task automatic new_cmd(input int port);
    logic        we;
    logic [5:0]  addr;
    logic [31:0] wd;
    we   = 1'($urandom_range(0, 1));
    addr = 6'($urandom_range(0, 7));
    wd   = $urandom;
    if (port == 0) begin bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wd; end
    else           begin bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wd; end
  endtask

  // Completed access on a port: check read data, then apply write to model.
  task automatic retire(input int port);
    logic        we;
    logic [5:0]  addr;
    logic [31:0] wd, rd;
    we   = (port == 0) ? bus.we0    : bus.we1;
    addr = (port == 0) ? bus.addr0  : bus.addr1;
    wd   = (port == 0) ? bus.wdata0 : bus.wdata1;
    rd   = (port == 0) ? bus.rdata0 : bus.rdata1;
    if (we) begin
      ref_mem[addr] = wd;
    end else begin
      n_checks++; if (rd !== ref_mem[addr]) begin n_errors++; $display("[TB] FAIL rdata port%0d addr=%0d got=%h exp=%h", port, addr, rd, ref_mem[addr]); end
    end
  endtask

  task automatic test_back_to_back();
    bit e0, e1;
    do_reset();
    new_cmd(0);
    new_cmd(1);
    for (int c = 1; c <= 16; c++) begin
      tick();
      e0 = (c % 4 == 2);
      e1 = (c % 4 == 0);
      n_checks++; if (bus.ack0 !== e0) begin n_errors++; $display("[TB] FAIL b2b_ack0 cycle=%0d got=%b exp=%b", c, bus.ack0, e0); end
      n_checks++; if (bus.ack1 !== e1) begin n_errors++; $display("[TB] FAIL b2b_ack1 cycle=%0d got=%b exp=%b", c, bus.ack1, e1); end
      if (bus.ack0 === 1'b1) begin retire(0); new_cmd(0); end
      if (bus.ack1 === 1'b1) begin retire(1); new_cmd(1); end
    end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_reset_mid_write();
    bit acked;
    do_reset();
    ram[3] = 32'hAAAA0000; ref_mem[3] = 32'hAAAA0000;
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 6'd3; bus.wdata0 = 32'h55555555;
    tick();
    n_checks++; if (bus.ram_wea !== 1'b1) begin n_errors++; $display("[TB] FAIL rstw_wea_access got=%b exp=1", bus.ram_wea); end
    rst = 1'b1;
    #1;
    n_checks++; if (bus.ram_wea !== 1'b0) begin n_errors++; $display("[TB] FAIL rstw_wea_drop got=%b exp=0", bus.ram_wea); end
    idle_inputs();
    acked = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (bus.ack0 === 1'b1) acked = 1'b1;
    end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (bus.ack0 === 1'b1) acked = 1'b1;
    end
    n_checks++; if (acked !== 1'b0) begin n_errors++; $display("[TB] FAIL rstw_no_ack0 got=%b exp=0", acked); end
    acked = 1'b0;
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 6'd3;
    for (int c = 0; c < 8 && !acked; c++) begin
      tick();
      if (bus.ack0 === 1'b1) begin
        acked = 1'b1;
        n_checks++; if (bus.rdata0 !== 32'hAAAA0000) begin n_errors++; $display("[TB] FAIL rstw_old_value got=%h exp=aaaa0000", bus.rdata0); end
        bus.req0 = 1'b0;
      end
    end
    n_checks++; if (acked !== 1'b1) begin n_errors++; $display("[TB] FAIL rstw_read_ack0 got=%b exp=1 (timeout)", acked); end
    tick();
  endtask

  task automatic test_dropped_pulse();
    bit seen0;
    do_reset();
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 6'd7;
    tick();
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 6'd2; bus.wdata0 = 32'hCAFEF00D;
    tick();
    n_checks++; if (bus.ack1 !== 1'b1) begin n_errors++; $display("[TB] FAIL pulse_ack1 got=%b exp=1", bus.ack1); end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    seen0 = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bus.ack0 === 1'b1 || bus.ram_wea === 1'b1) seen0 = 1'b1;
    end
    n_checks++; if (seen0 !== 1'b0) begin n_errors++; $display("[TB] FAIL pulse_no_grant got=%b exp=0", seen0); end
  endtask

  task automatic test_random();
    bit pend [2];
    int wait_cnt [2];
    do_reset();
    pend[0] = 1'b0; pend[1] = 1'b0;
    wait_cnt[0] = 0; wait_cnt[1] = 0;
    for (int c = 0; c < 400; c++) begin
      tick();
      n_checks++; if (bus.ack0 === 1'b1 && bus.ack1 === 1'b1) begin n_errors++; $display("[TB] FAIL rand_dual_ack cycle=%0d got=11 exp=not both", c); end
      for (int p = 0; p < 2; p++) begin
        logic ack_p;
        ack_p = (p == 0) ? bus.ack0 : bus.ack1;
        if (ack_p === 1'b1) begin
          n_checks++; if (pend[p] !== 1'b1) begin n_errors++; $display("[TB] FAIL rand_spurious_ack port%0d got=1 exp=0", p); end
          if (pend[p]) retire(p);
          pend[p] = 1'b0;
          wait_cnt[p] = 0;
          if (p == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
        end else if (pend[p]) begin
          wait_cnt[p]++;
          if (wait_cnt[p] > 6) begin
            n_checks++; n_errors++;
            $display("[TB] FAIL rand_timeout port%0d waited=%0d exp<=6", p, wait_cnt[p]);
            pend[p] = 1'b0;
            wait_cnt[p] = 0;
            if (p == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          new_cmd(p);
          pend[p] = 1'b1;
        end
      end
    end
    idle_inputs();
    tick();
    tick();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      ram[i]     = $urandom;
      ref_mem[i] = ram[i];
    end
    rst = 1'b1;
    idle_inputs();
    $display("[TB] starting spram_arbiter bench");
    test_reset();
    test_single_read();
    test_write_read();
    test_both_same_cycle();
    test_back_to_back();
    test_reset_mid_write();
    test_dropped_pulse();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/spram_arbiter.md
Name: spram_arbiter

Overview:
- Shares the single-port 64x32 synchronous RAM (SPRAM) between two requesters: port 0 for instruction fetch and port 1 for data load/store.
- Each requester uses a req/ack handshake. A round-robin scheduler serialises their accesses onto the one RAM port.
- Sits between the MIPS fetch/memory stages and the SPRAM instance.
- One access completes every 2 cycles at full load.

Parameters:
- ADDR_W, 6, RAM address width (64 words).
- DATA_W, 32, RAM data width.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0  in  1  port 0 request; held with we0/addr0/wdata0 stable until ack0.
- we0  in  1  port 0 write enable (1 = write, 0 = read).
- addr0  in  ADDR_W  port 0 word address.
- wdata0  in  DATA_W  port 0 write data.
- ack0  out  1  one-cycle completion pulse for port 0.
- rdata0  out  DATA_W  port 0 read data; valid only while ack0=1.
- req1, we1, addr1, wdata1, ack1, rdata1: same as port 0, for port 1.
- ram_wea  out  1  SPRAM write enable.
- ram_addra  out  ADDR_W  SPRAM address.
- ram_dina  out  DATA_W  SPRAM write data.
- ram_douta  in  DATA_W  SPRAM read data, 1-cycle latency after address.

Behaviour:
- Clock is clk. Reset rst is asynchronous and active-high.
- Reset values:
  - state=IDLE.
  - ack0=ack1=0.
  - ram_wea=0, ram_addra=0, ram_dina=0.
  - Latched command registers = 0.
  - last_grant=1, so port 0 wins the first tie.
- FSM states are IDLE, ACCESS and RESP.
- IDLE:
  - If any req is high, pick a winner, latch its we/addr/wdata and the winner id, then go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS:
  - ram_addra and ram_dina come from the latched registers.
  - ram_wea = latched we. It is high only in ACCESS.
  - Always go to RESP.
- RESP:
  - ack[winner]=1 for exactly this cycle.
  - rdata[winner] = ram_douta, which holds the read data; for a write it is don't-care.
  - At the end of RESP, arbitrate again with the current winner's req masked.
  - If the other port's req is high, latch it and go straight to ACCESS. Otherwise go to IDLE.
- Arbitration:
  - Only one req high: that port wins.
  - Both high: the port not equal to last_grant wins.
  - last_grant updates to the winner at every latch.
- Latency: a req sampled high in IDLE at edge k gives ACCESS in cycle k+1 and ack in cycle k+2.
- Requester rules:
  - A requester must drop req, or present a new command, in the cycle after its ack.
  - A new req from the same port is accepted from IDLE at the earliest.
- rdata0 and rdata1 are combinational copies of ram_douta; they are meaningful only with their ack.
- Changing a command while req is high and before ack is illegal. The latched copy is used.
- A req that drops before being granted is simply not served; no ack is issued.
- Reset mid-operation:
  - Asserting rst during ACCESS forces ram_wea low immediately, so no write is committed if rst is asserted before the edge.
  - No ack is issued for an access cut off by reset.
- Simultaneous ack0 and ack1 is impossible by construction.

Decomposition:
- Shared package spram_arb_pkg holds:
  - the state enum (IDLE, ACCESS, RESP);
  - ADDR_W and DATA_W defaults;
  - port-id constants PORT_FETCH=0 and PORT_DATA=1.
- One sub-module, rr_arbiter2:
  - Inputs: req vector, mask, last_grant.
  - Outputs: grant_valid, grant_id.
  - Purely combinational.
- Latch registers and the FSM live in spram_arbiter.

Test Plan:
- Reset, then req0 read addr=5 alone (RAM preloaded: word 5 = 0xDEADBEEF) -> ram_addra=5 in cycle 1; ack0=1 and rdata0=0xDEADBEEF in cycle 2; ack1 stays 0.
- req1 write addr=10 data=0x12345678, then req1 read addr=10 -> ram_wea=1 for exactly one cycle; second ack1 returns 0x12345678.
- req0 and req1 both rise in the same cycle after reset -> port 0 is served first. Port 1 goes ACCESS directly from RESP, ack1 arrives 2 cycles after ack0, and there is no IDLE gap.
- Both reqs held continuously for 8 accesses -> acks alternate 0,1,0,1..., one ack every 2 cycles, no starvation.
- rst asserted during ACCESS of a write to addr 3 (old value 0xAAAA0000) -> ram_wea drops immediately; ack0 is never seen; later read of addr 3 returns 0xAAAA0000.
- req0 pulsed high for 1 cycle while port 1 is being served, then dropped -> port 0 is never granted and ack0 stays 0.
